mmu_tlb: RTL and testbench

//  Next-generation address translation for the MIPS core. Unmapped kseg0/kseg1 strip the top 3 bits as before.

---
 rtl/mmu_tlb_pkg.sv | 46 ++++
 rtl/mmu_tlb_lookup.sv | 44 ++++
 rtl/mmu_tlb.sv | 184 ++++++++++++++++++
 tb/tb_mmu_tlb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_tlb_pkg.sv
// mmu_tlb_pkg
//   Shared definitions for the MIPS address-translation unit.
//   - Segment codes for vaddr[31:29] (unmapped kseg0/kseg1).
//   - Packed TLB entry layout, from MSB to LSB:
//       {VPN2[18:0], ASID[ASID_W-1:0], G, PFN0[19:0], C0[2:0], D0, V0, PFN1[19:0], C1[2:0], D1, V1}
//     Field offsets are counted from the LSB so they do not depend on ASID_W.
//     The tag part {VPN2, ASID, G} is everything from G_POS upwards.
//   - Per-lookup response record and exception encoding.
package mmu_tlb_pkg;

    localparam logic [2:0] SEG_KSEG0   = 3'b100;
    localparam logic [2:0] SEG_KSEG1   = 3'b101;
    localparam logic [2:0] C_CACHEABLE = 3'd3;

    localparam int VPN2_W = 19;
    localparam int PFN_W  = 20;

    // One page half: {PFN, C, D, V}
    localparam int HALF_W       = PFN_W + 5;
    localparam int HALF_V       = 0;
    localparam int HALF_D       = 1;
    localparam int HALF_C_LSB   = 2;
    localparam int HALF_PFN_LSB = 5;

    // Odd page sits in the low half of the pair, even page above it
    localparam int ODD_LSB  = 0;
    localparam int EVEN_LSB = HALF_W;
    localparam int PAIR_W   = 2 * HALF_W;

    localparam int G_POS    = PAIR_W;
    localparam int ASID_LSB = G_POS + 1;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_REFILL   = 2'd1,
        EXC_INVALID  = 2'd2,
        EXC_MODIFIED = 2'd3
    } exc_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        exc_t        exc;
    } resp_t;

endpackage

// File: rtl/mmu_tlb_lookup.sv
// mmu_tlb_lookup
//   Combinational fully-associative match of one VPN2/ASID against every
//   TLB tag. Lowest matching index wins when several entries hit.
// Ports
//   tags     in   TLB_ENTRIES x {VPN2, ASID, G}, entry i at [i*TAG_W +: TAG_W]
//   present  in   per-entry written flag; unwritten entries never match
//   vpn2     in   virtual page-pair number to look up
//   asid     in   current address-space identifier
//   hit      out  at least one entry matched
//   index    out  lowest matching index (0 when no hit)
module mmu_tlb_lookup
    import mmu_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int ASID_W      = 8,
    localparam int TAG_W      = VPN2_W + ASID_W + 1
) (
    input  logic [TLB_ENTRIES*TAG_W-1:0] tags,
    input  logic [TLB_ENTRIES-1:0]       present,
    input  logic [VPN2_W-1:0]            vpn2,
    input  logic [ASID_W-1:0]            asid,
    output logic                         hit,
    output logic [IDX_W-1:0]             index
);

    logic [TAG_W-1:0] tag;

    // Scan from the top down so the last assignment is the lowest hit.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        tag   = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            tag = tags[i*TAG_W +: TAG_W];
            if (present[i] && (tag[TAG_W-1 -: VPN2_W] == vpn2) &&
                (tag[0] || (tag[ASID_W:1] == asid))) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb
//   MIPS address translation: kseg0/kseg1 unmapped, other segments through a
//   fully-associative TLB of even/odd 4KB page pairs with ASID. One fetch and
//   one data lookup per cycle, registered one-cycle responses, plus CP0
//   TLBWI (write), TLBR (combinational read) and TLBP (probe).
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   stall                       hold fetch/data response registers, drop requests
//   asid, k0_cached             EntryHi.ASID, Config.K0 == 3
//   inst_req/inst_vaddr         fetch lookup -> inst_rvalid/paddr/uncached/refill/invalid
//   data_req/data_vaddr/data_wr data lookup  -> data_rvalid/paddr/uncached/refill/invalid/modified
//   tlb_we/tlb_idx/tlb_wentry   TLBWI write; tlb_rentry is the TLBR read of tlb_idx
//   tlbp_req/tlbp_vpn2          TLBP probe -> tlbp_rvalid/tlbp_miss/tlbp_index
module mmu_tlb
    import mmu_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int ASID_W      = 8,
    parameter bit MAPPED_EN   = 1'b1,
    localparam int ENTRY_W    = ASID_LSB + ASID_W + VPN2_W,
    localparam int TAG_W      = VPN2_W + ASID_W + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall,
    input  logic [ASID_W-1:0]  asid,
    input  logic               k0_cached,

    input  logic               inst_req,
    input  logic [31:0]        inst_vaddr,
    output logic               inst_rvalid,
    output logic [31:0]        inst_paddr,
    output logic               inst_uncached,
    output logic               inst_refill,
    output logic               inst_invalid,

    input  logic               data_req,
    input  logic [31:0]        data_vaddr,
    input  logic               data_wr,
    output logic               data_rvalid,
    output logic [31:0]        data_paddr,
    output logic               data_uncached,
    output logic               data_refill,
    output logic               data_invalid,
    output logic               data_modified,

    input  logic               tlb_we,
    input  logic [IDX_W-1:0]   tlb_idx,
    input  logic [ENTRY_W-1:0] tlb_wentry,
    output logic [ENTRY_W-1:0] tlb_rentry,

    input  logic               tlbp_req,
    input  logic [VPN2_W-1:0]  tlbp_vpn2,
    output logic               tlbp_rvalid,
    output logic               tlbp_miss,
    output logic [IDX_W-1:0]   tlbp_index
);

    logic [TLB_ENTRIES*ENTRY_W-1:0] entry_flat;
    logic [TLB_ENTRIES-1:0]         present;
    logic [TLB_ENTRIES*TAG_W-1:0]   tag_flat;

    logic             inst_hit, data_hit, probe_hit;
    logic [IDX_W-1:0] inst_index, data_index, probe_index;
    logic [PAIR_W-1:0] inst_pair, data_pair;
    resp_t            inst_next, data_next;
    resp_t            inst_q, data_q;

    // Entry storage; writes are honoured regardless of stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry_flat <= '0;
            present    <= '0;
        end else if (tlb_we) begin
            entry_flat[int'(tlb_idx)*ENTRY_W +: ENTRY_W] <= tlb_wentry;
            present[tlb_idx]                             <= 1'b1;
        end
    end

    assign tlb_rentry = entry_flat[int'(tlb_idx)*ENTRY_W +: ENTRY_W];

    always_comb begin
        tag_flat = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            tag_flat[i*TAG_W +: TAG_W] = entry_flat[i*ENTRY_W + G_POS +: TAG_W];
        end
    end

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_inst_lookup (
        .tags(tag_flat), .present(present), .vpn2(inst_vaddr[31:13]), .asid(asid),
        .hit(inst_hit), .index(inst_index)
    );

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_data_lookup (
        .tags(tag_flat), .present(present), .vpn2(data_vaddr[31:13]), .asid(asid),
        .hit(data_hit), .index(data_index)
    );

    mmu_tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_probe_lookup (
        .tags(tag_flat), .present(present), .vpn2(tlbp_vpn2), .asid(asid),
        .hit(probe_hit), .index(probe_index)
    );

    assign inst_pair = entry_flat[int'(inst_index)*ENTRY_W +: PAIR_W];
    assign data_pair = entry_flat[int'(data_index)*ENTRY_W +: PAIR_W];

    // Segment decode and exception encode for one lookup. The exception
    // chain order gives refill > invalid > modified; any exception leaves
    // paddr and uncached at zero.
    function automatic resp_t translate(input logic [31:0]       va,
                                        input logic              wr,
                                        input logic              kc,
                                        input logic              hit,
                                        input logic [PAIR_W-1:0] pair);
        resp_t             r;
        logic [HALF_W-1:0] half;
        r    = '0;
        half = va[12] ? pair[ODD_LSB +: HALF_W] : pair[EVEN_LSB +: HALF_W];
        if (va[31:29] == SEG_KSEG0 || va[31:29] == SEG_KSEG1) begin
            r.paddr    = {3'b000, va[28:0]};
            r.uncached = (va[31:29] == SEG_KSEG1) || !kc;
        end else if (!MAPPED_EN) begin
            r.paddr = va;
        end else if (!hit) begin
            r.exc = EXC_REFILL;
        end else if (!half[HALF_V]) begin
            r.exc = EXC_INVALID;
        end else if (wr && !half[HALF_D]) begin
            r.exc = EXC_MODIFIED;
        end else begin
            r.paddr    = {half[HALF_PFN_LSB +: PFN_W], va[11:0]};
            r.uncached = (half[HALF_C_LSB +: 3] != C_CACHEABLE);
        end
        return r;
    endfunction

    always_comb begin
        inst_next = translate(inst_vaddr, 1'b0, k0_cached, inst_hit, inst_pair);
        data_next = translate(data_vaddr, data_wr, k0_cached, data_hit, data_pair);
    end

    // Response registers. Fetch/data freeze under stall; the probe path
    // does not look at stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rvalid <= 1'b0;
            inst_q      <= '0;
            data_rvalid <= 1'b0;
            data_q      <= '0;
            tlbp_rvalid <= 1'b0;
            tlbp_miss   <= 1'b0;
            tlbp_index  <= '0;
        end else begin
            if (!stall) begin
                inst_rvalid <= inst_req;
                data_rvalid <= data_req;
                if (inst_req) begin
                    inst_q <= inst_next;
                end
                if (data_req) begin
                    data_q <= data_next;
                end
            end
            tlbp_rvalid <= tlbp_req;
            if (tlbp_req) begin
                tlbp_miss  <= !probe_hit;
                tlbp_index <= probe_hit ? probe_index : '0;
            end
        end
    end

    assign inst_paddr    = inst_q.paddr;
    assign inst_uncached = inst_q.uncached;
    assign inst_refill   = (inst_q.exc == EXC_REFILL);
    assign inst_invalid  = (inst_q.exc == EXC_INVALID);

    assign data_paddr    = data_q.paddr;
    assign data_uncached = data_q.uncached;
    assign data_refill   = (data_q.exc == EXC_REFILL);
    assign data_invalid  = (data_q.exc == EXC_INVALID);
    assign data_modified = (data_q.exc == EXC_MODIFIED);

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb
//   Directed bench for mmu_tlb with default parameters (16 entries, ASID 8 bits).
//   Expected lookup responses are pushed to a scoreboard queue when the
//   request is driven and popped when the registered response appears.
module tb_mmu_tlb;

    localparam int ENTRY_W = 78;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               stall = 1'b0;
    logic [7:0]         asid = '0;
    logic               k0_cached = 1'b0;
    logic               inst_req = 1'b0;
    logic [31:0]        inst_vaddr = '0;
    logic               inst_rvalid;
    logic [31:0]        inst_paddr;
    logic               inst_uncached, inst_refill, inst_invalid;
    logic               data_req = 1'b0;
    logic [31:0]        data_vaddr = '0;
    logic               data_wr = 1'b0;
    logic               data_rvalid;
    logic [31:0]        data_paddr;
    logic               data_uncached, data_refill, data_invalid, data_modified;
    logic               tlb_we = 1'b0;
    logic [3:0]         tlb_idx = '0;
    logic [ENTRY_W-1:0] tlb_wentry = '0;
    logic [ENTRY_W-1:0] tlb_rentry;
    logic               tlbp_req = 1'b0;
    logic [18:0]        tlbp_vpn2 = '0;
    logic               tlbp_rvalid, tlbp_miss;
    logic [3:0]         tlbp_index;

    always #5 clk = ~clk;

    mmu_tlb dut (
        .clk(clk), .resetn(resetn), .stall(stall), .asid(asid), .k0_cached(k0_cached),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_rvalid(inst_rvalid),
        .inst_paddr(inst_paddr), .inst_uncached(inst_uncached),
        .inst_refill(inst_refill), .inst_invalid(inst_invalid),
        .data_req(data_req), .data_vaddr(data_vaddr), .data_wr(data_wr),
        .data_rvalid(data_rvalid), .data_paddr(data_paddr), .data_uncached(data_uncached),
        .data_refill(data_refill), .data_invalid(data_invalid), .data_modified(data_modified),
        .tlb_we(tlb_we), .tlb_idx(tlb_idx), .tlb_wentry(tlb_wentry), .tlb_rentry(tlb_rentry),
        .tlbp_req(tlbp_req), .tlbp_vpn2(tlbp_vpn2), .tlbp_rvalid(tlbp_rvalid),
        .tlbp_miss(tlbp_miss), .tlbp_index(tlbp_index)
    );

    typedef struct {
        bit          is_data;
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        modified;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [ENTRY_W-1:0] e3, e7, e2a, e2b, e5;

    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [18:0] vpn2, input logic [7:0] easid, input logic g,
        input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn2, easid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tlb_write(input logic [3:0] idx, input logic [ENTRY_W-1:0] ent);
        tlb_we     = 1'b1;
        tlb_idx    = idx;
        tlb_wentry = ent;
        step();
        tlb_we = 1'b0;
    endtask

    // Drive one lookup for a single cycle and queue its expected response.
    task automatic applyStimulus(input bit is_data, input logic [31:0] va, input logic wr,
                                 input logic [31:0] paddr, input logic unc, input logic refill,
                                 input logic invalid, input logic modified, input string tag);
        exp_t e;
        e.is_data  = is_data;
        e.paddr    = paddr;
        e.uncached = unc;
        e.refill   = refill;
        e.invalid  = invalid;
        e.modified = modified;
        e.tag      = tag;
        sb.push_back(e);
        if (is_data) begin
            data_req   = 1'b1;
            data_vaddr = va;
            data_wr    = wr;
        end else begin
            inst_req   = 1'b1;
            inst_vaddr = va;
        end
        step();
        inst_req = 1'b0;
        data_req = 1'b0;
        data_wr  = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;
        chk("scoreboard_nonempty", 128'(sb.size() != 0), 128'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.is_data) begin
            chk({e.tag, ".rvalid"},   data_rvalid,   1'b1);
            chk({e.tag, ".paddr"},    data_paddr,    e.paddr);
            chk({e.tag, ".uncached"}, data_uncached, e.uncached);
            chk({e.tag, ".refill"},   data_refill,   e.refill);
            chk({e.tag, ".invalid"},  data_invalid,  e.invalid);
            chk({e.tag, ".modified"}, data_modified, e.modified);
        end else begin
            chk({e.tag, ".rvalid"},   inst_rvalid,   1'b1);
            chk({e.tag, ".paddr"},    inst_paddr,    e.paddr);
            chk({e.tag, ".uncached"}, inst_uncached, e.uncached);
            chk({e.tag, ".refill"},   inst_refill,   e.refill);
            chk({e.tag, ".invalid"},  inst_invalid,  e.invalid);
        end
    endtask

    task automatic probe(input logic [18:0] vpn2, input logic miss, input logic [3:0] idx,
                         input string tag);
        tlbp_req  = 1'b1;
        tlbp_vpn2 = vpn2;
        step();
        tlbp_req = 1'b0;
        chk({tag, ".rvalid"}, tlbp_rvalid, 1'b1);
        chk({tag, ".miss"},   tlbp_miss,   miss);
        chk({tag, ".index"},  tlbp_index,  idx);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        e3  = make_entry(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1, 20'h0ABCD, 3'd2, 1'b1, 1'b0);
        e7  = make_entry(19'h00200, 8'd9, 1'b1, 20'h77777, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e2a = make_entry(19'h00200, 8'd5, 1'b0, 20'h22222, 3'd2, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e2b = make_entry(19'h00200, 8'd5, 1'b0, 20'h33333, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e5  = make_entry(19'h00555, 8'd1, 1'b0, 20'h55555, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.inst_rvalid", inst_rvalid, 1'b0);
        chk("rst.data_rvalid", data_rvalid, 1'b0);
        chk("rst.tlbp_rvalid", tlbp_rvalid, 1'b0);
        chk("rst.inst_paddr",  inst_paddr,  32'h0);
        chk("rst.data_flags",  {data_uncached, data_refill, data_invalid, data_modified}, 4'b0);
        chk("rst.rentry0",     tlb_rentry,  '0);
        @(negedge clk);
        resetn = 1'b1;

        // Unmapped segments
        applyStimulus(0, 32'hBFC00000, 0, 32'h1FC00000, 1, 0, 0, 0, "kseg1_fetch");
        checkOutput();
        k0_cached = 1'b1;
        applyStimulus(1, 32'h80001234, 0, 32'h00001234, 0, 0, 0, 0, "kseg0_cached");
        checkOutput();
        k0_cached = 1'b0;
        applyStimulus(1, 32'h80001234, 0, 32'h00001234, 1, 0, 0, 0, "kseg0_uncached");
        checkOutput();

        // Mapped lookups
        applyStimulus(1, 32'h00400000, 0, 32'h0, 0, 1, 0, 0, "empty_refill");
        checkOutput();
        tlb_write(4'd3, e3);
        chk("tlbr_idx3", tlb_rentry, e3);
        asid = 8'd5;
        applyStimulus(1, 32'h00400ABC, 0, 32'h12345ABC, 0, 0, 0, 0, "map_load");
        checkOutput();
        applyStimulus(1, 32'h00400ABC, 1, 32'h0, 0, 0, 0, 1, "map_store_mod");
        checkOutput();
        asid = 8'd6;
        applyStimulus(1, 32'h00400ABC, 0, 32'h0, 0, 1, 0, 0, "asid_refill");
        checkOutput();
        asid = 8'd5;
        applyStimulus(1, 32'h00401000, 0, 32'h0, 0, 0, 1, 0, "odd_invalid");
        checkOutput();

        // Multiple hits and global entry
        tlb_write(4'd7, e7);
        tlb_write(4'd2, e2a);
        applyStimulus(1, 32'h00400ABC, 0, 32'h22222ABC, 1, 0, 0, 0, "multi_lowest");
        checkOutput();
        applyStimulus(0, 32'h00400ABC, 0, 32'h22222ABC, 1, 0, 0, 0, "multi_fetch");
        checkOutput();
        applyStimulus(1, 32'h00400ABC, 1, 32'h22222ABC, 1, 0, 0, 0, "store_dirty");
        checkOutput();
        asid = 8'd6;
        applyStimulus(1, 32'h00400ABC, 0, 32'h77777ABC, 0, 0, 0, 0, "global_hit");
        checkOutput();
        asid = 8'd5;
        probe(19'h00200, 1'b0, 4'd2, "probe_hit");
        probe(19'h00300, 1'b1, 4'd0, "probe_miss");

        // Write and lookup in the same cycle: old contents, then new
        tlb_we     = 1'b1;
        tlb_idx    = 4'd2;
        tlb_wentry = e2b;
        applyStimulus(1, 32'h00400ABC, 0, 32'h22222ABC, 1, 0, 0, 0, "same_cycle_old");
        tlb_we = 1'b0;
        checkOutput();
        applyStimulus(1, 32'h00400ABC, 0, 32'h33333ABC, 0, 0, 0, 0, "next_cycle_new");
        checkOutput();

        // Stall: responses frozen, request dropped, write and probe still work
        applyStimulus(1, 32'h80001234, 0, 32'h00001234, 1, 0, 0, 0, "pre_stall");
        checkOutput();
        stall      = 1'b1;
        data_req   = 1'b1;
        data_vaddr = 32'h00400ABC;
        tlb_we     = 1'b1;
        tlb_idx    = 4'd5;
        tlb_wentry = e5;
        asid       = 8'd6;
        tlbp_req   = 1'b1;
        tlbp_vpn2  = 19'h00200;
        for (int i = 0; i < 3; i++) begin
            step();
            tlb_we   = 1'b0;
            tlbp_req = 1'b0;
            chk("stall.rvalid",   data_rvalid,   1'b1);
            chk("stall.paddr",    data_paddr,    32'h00001234);
            chk("stall.uncached", data_uncached, 1'b1);
            if (i == 0) begin
                chk("stall_probe.rvalid", tlbp_rvalid, 1'b1);
                chk("stall_probe.miss",   tlbp_miss,   1'b0);
                chk("stall_probe.index",  tlbp_index,  4'd7);
            end
        end
        stall    = 1'b0;
        data_req = 1'b0;
        step();
        chk("dropped.rvalid",  data_rvalid, 1'b0);
        chk("idle.tlbp_valid", tlbp_rvalid, 1'b0);
        tlb_idx = 4'd5;
        #1;
        chk("stall_write", tlb_rentry, e5);

        // Asynchronous reset mid-stream
        asid       = 8'd5;
        data_req   = 1'b1;
        data_vaddr = 32'h00400ABC;
        step();
        data_req = 1'b0;
        chk("pre_reset.rvalid", data_rvalid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst.rvalid", data_rvalid, 1'b0);
        chk("async_rst.paddr",  data_paddr,  32'h0);
        tlb_idx = 4'd3;
        #1;
        chk("async_rst.rentry3", tlb_rentry, '0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1, 32'h00400ABC, 0, 32'h0, 0, 1, 0, 0, "post_rst_refill");
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
